qpsk_rx_msg_fifo: RTL and testbench

- Byte buffer directly downstream of the qpsk demapper. Consumes its demapped characters (data/data_valid) and stores printable text plus end-of-message markers.
- Presents buffered characters to the message consumer over a valid/ready interface with an end-of-message flag.
- Decouples the demapper's bursty, irregular char rate from a consumer that may stall.

---
 rtl/qpsk_rx_msg_fifo_if.sv | 42 ++++
 rtl/qpsk_rx_msg_fifo.sv | 155 +++++++++++++++
 tb/tb_qpsk_rx_msg_fifo.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_rx_msg_fifo_if.sv
// qpsk_rx_msg_fifo_if
//   Groups the two character streams around the receive message FIFO:
//   the demapper write stream (no backpressure) and the consumer read
//   stream (valid/ready with end-of-message flag).
//
//   Signals:
//     data_in        demapped character from the qpsk demapper
//     data_in_valid  data_in is valid this cycle
//     out_data       character at the FIFO head
//     out_eom        head entry is an end-of-message marker
//     out_valid      head entry present
//     out_ready      consumer accepts the head entry
//
//   Modports:
//     slave   the FIFO itself (consumes data_in, drives out_*)
//     master  the surrounding logic (drives data_in, consumes out_*)
interface qpsk_rx_msg_fifo_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic [7:0] out_data;
  logic       out_eom;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  data_in,
    input  data_in_valid,
    input  out_ready,
    output out_data,
    output out_eom,
    output out_valid
  );

  modport master (
    output data_in,
    output data_in_valid,
    output out_ready,
    input  out_data,
    input  out_eom,
    input  out_valid
  );
endinterface

// File: rtl/qpsk_rx_msg_fifo.sv
// qpsk_rx_msg_fifo
//   Byte buffer directly after the qpsk demapper. Printable text bytes
//   (0x01..0x7F) are stored as-is; a terminator (0x00 or 0xFF) that closes
//   an open message is stored as an end-of-message marker {1, 8'h00}.
//   Terminators outside a message are ignored, and 0x80..0xFE bytes are
//   discarded and flagged. The head entry is presented first-word
//   fall-through on a valid/ready interface.
//
//   Ports:
//     clk        system clock, rising edge
//     reset      asynchronous active-low reset
//     bus        qpsk_rx_msg_fifo_if.slave (write and read streams)
//     level      occupied entries, 0..DEPTH
//     full       level == DEPTH
//     empty      level == 0
//     msg_count  complete messages currently stored (saturating)
//     overflow   sticky: a storable byte was dropped while full
//     bad_char   sticky: a byte in 0x80..0xFE was received
module qpsk_rx_msg_fifo #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int MSG_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  qpsk_rx_msg_fifo_if.slave    bus,
  output logic [ADDR_W:0]      level,
  output logic                 full,
  output logic                 empty,
  output logic [MSG_CNT_W-1:0] msg_count,
  output logic                 overflow,
  output logic                 bad_char
);

  localparam logic [ADDR_W:0]      FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
  localparam logic [MSG_CNT_W-1:0] CNT_MAX    = '1;

  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              msg_open;

  logic       is_text;
  logic       is_term;
  logic       is_bad;
  logic       storable;
  logic       wr_en;
  logic       wr_drop;
  logic       rd_en;
  logic       wr_eom;
  logic       rd_eom;
  logic [8:0] wr_entry;
  logic [8:0] head;

  assign head          = mem[rd_ptr];
  assign bus.out_data  = head[7:0];
  assign bus.out_eom   = head[8];
  assign bus.out_valid = !empty;
  assign empty         = (level == '0);
  assign full          = (level == FULL_LEVEL);

  // A terminator is only storable while a message is open, so runs of
  // terminators collapse to a single marker. Acceptance looks at full
  // before any same-cycle read.
  always_comb begin
    is_text  = 1'b0;
    is_term  = 1'b0;
    is_bad   = 1'b0;
    wr_entry = {1'b0, bus.data_in};
    if (bus.data_in_valid) begin
      if (bus.data_in == 8'h00 || bus.data_in == 8'hFF) begin
        is_term  = 1'b1;
        wr_entry = {1'b1, 8'h00};
      end else if (bus.data_in[7]) begin
        is_bad = 1'b1;
      end else begin
        is_text = 1'b1;
      end
    end
    storable = is_text || (is_term && msg_open);
    wr_en    = storable && !full;
    wr_drop  = storable && full;
    rd_en    = bus.out_valid && bus.out_ready;
    wr_eom   = wr_en && is_term;
    rd_eom   = rd_en && bus.out_eom;
  end

  // Storage array is not reset; entries beyond level are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers and occupancy. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        level <= level + 1'b1;
      end else if (rd_en && !wr_en) begin
        level <= level - 1'b1;
      end
    end
  end

  // Message tracking. A dropped terminator leaves the message open so the
  // following bytes are still treated as part of it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_open  <= 1'b0;
      msg_count <= '0;
    end else begin
      if (is_text) begin
        msg_open <= 1'b1;
      end else if (wr_eom) begin
        msg_open <= 1'b0;
      end
      if (wr_eom && !rd_eom) begin
        if (msg_count != CNT_MAX) begin
          msg_count <= msg_count + 1'b1;
        end
      end else if (rd_eom && !wr_eom) begin
        if (msg_count != '0) begin
          msg_count <= msg_count - 1'b1;
        end
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      bad_char <= 1'b0;
    end else begin
      if (wr_drop) begin
        overflow <= 1'b1;
      end
      if (is_bad) begin
        bad_char <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_rx_msg_fifo.sv
// tb_qpsk_rx_msg_fifo
//   Directed bench for qpsk_rx_msg_fifo. Stimulus pushes hand-computed
//   expected head entries into a scoreboard queue; an independent monitor
//   pops and compares on every accepted read beat. Status outputs are
//   checked directly against hand-computed constants.
module tb_qpsk_rx_msg_fifo;

  logic       clk;
  logic       reset;
  logic [6:0] level;
  logic       full;
  logic       empty;
  logic [3:0] msg_count;
  logic       overflow;
  logic       bad_char;

  int compared;
  int mismatched;

  logic [8:0] exp_q [$];

  qpsk_rx_msg_fifo_if bus ();

  qpsk_rx_msg_fifo #(
    .DEPTH(64),
    .ADDR_W(6),
    .MSG_CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .level(level),
    .full(full),
    .empty(empty),
    .msg_count(msg_count),
    .overflow(overflow),
    .bad_char(bad_char)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Generic scalar comparison used by all directed checks.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every beat the consumer accepts must match the queue head.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL beat: got {%0b,0x%02h}, expected no beat",
                 bus.out_eom, bus.out_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({bus.out_eom, bus.out_data} !== e) begin
          mismatched++;
          $display("[TB] FAIL beat: got {%0b,0x%02h}, expected {%0b,0x%02h}",
                   bus.out_eom, bus.out_data, e[8], e[7:0]);
        end
      end
    end
  end

  // Drive one byte for exactly one rising edge; called at posedge+1.
  task automatic apply_stimulus(input logic [7:0] b);
    bus.data_in       = b;
    bus.data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
  endtask

  task automatic expect_beat(input logic eom, input logic [7:0] b);
    exp_q.push_back({eom, b});
  endtask

  // Drain with out_ready=1 until empty, bounded by a cycle budget.
  task automatic drain(input string name);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (empty !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.out_ready = 1'b0;
    check_output({name, "_drained"}, {31'd0, empty}, 32'd1);
    check_output({name, "_queue_left"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    compared          = 0;
    mismatched        = 0;
    reset             = 1'b0;
    bus.data_in       = 8'h00;
    bus.data_in_valid = 1'b0;
    bus.out_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check_output("rst_level", level, 32'd0);
    check_output("rst_empty", empty, 32'd1);
    check_output("rst_full", full, 32'd0);
    check_output("rst_out_valid", bus.out_valid, 32'd0);
    check_output("rst_msg_count", msg_count, 32'd0);
    check_output("rst_overflow", overflow, 32'd0);
    check_output("rst_bad_char", bad_char, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Leading terminator on a fresh FIFO is ignored
    apply_stimulus(8'h00);
    check_output("lead_term_level", level, 32'd0);

    // "HI" + terminator, held, then drained
    apply_stimulus(8'h48); expect_beat(1'b0, 8'h48);
    apply_stimulus(8'h49); expect_beat(1'b0, 8'h49);
    apply_stimulus(8'h00); expect_beat(1'b1, 8'h00);
    check_output("hi_level", level, 32'd3);
    check_output("hi_msg_count", msg_count, 32'd1);
    drain("hi");
    check_output("hi_msg_count_after", msg_count, 32'd0);

    // Terminator collapsing and 0xFF normalisation
    apply_stimulus(8'h41); expect_beat(1'b0, 8'h41);
    apply_stimulus(8'hFF); expect_beat(1'b1, 8'h00);
    apply_stimulus(8'h00);
    apply_stimulus(8'hFF);
    apply_stimulus(8'h42); expect_beat(1'b0, 8'h42);
    check_output("term_level", level, 32'd3);
    check_output("term_msg_count", msg_count, 32'd1);
    drain("term");

    // Fill to full, overflow on the 65th byte, drain across the wrap
    for (int i = 1; i <= 64; i++) begin
      apply_stimulus(8'(i));
      expect_beat(1'b0, 8'(i));
    end
    check_output("fill_full", full, 32'd1);
    check_output("fill_level", level, 32'd64);
    check_output("fill_overflow_before", overflow, 32'd0);
    apply_stimulus(8'h41);
    check_output("fill_overflow", overflow, 32'd1);
    check_output("fill_level_after_drop", level, 32'd64);
    drain("fill");

    // Out-of-range byte flagged and discarded
    apply_stimulus(8'h41); expect_beat(1'b0, 8'h41);
    apply_stimulus(8'h85);
    apply_stimulus(8'h42); expect_beat(1'b0, 8'h42);
    check_output("bad_bad_char", bad_char, 32'd1);
    check_output("bad_level", level, 32'd2);
    drain("bad");

    // Simultaneous write and read at level 10
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(8'(8'h50 + i));
      expect_beat(1'b0, 8'(8'h50 + i));
    end
    check_output("sim_level_before", level, 32'd10);
    check_output("sim_head_before", bus.out_data, 32'h50);
    bus.out_ready = 1'b1;
    apply_stimulus(8'h5A); expect_beat(1'b0, 8'h5A);
    bus.out_ready = 1'b0;
    check_output("sim_level_after", level, 32'd10);
    check_output("sim_head_after", bus.out_data, 32'h51);
    drain("sim");

    // First-word fall-through latency on an empty FIFO
    bus.data_in       = 8'h60;
    bus.data_in_valid = 1'b1;
    check_output("lat_valid_before", bus.out_valid, 32'd0);
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
    expect_beat(1'b0, 8'h60);
    check_output("lat_valid_after", bus.out_valid, 32'd1);
    check_output("lat_data", bus.out_data, 32'h60);
    drain("lat");

    // Asynchronous reset mid-message at level 5 with overflow still set
    apply_stimulus(8'h61);
    apply_stimulus(8'h00);
    apply_stimulus(8'h62);
    apply_stimulus(8'h63);
    apply_stimulus(8'h64);
    check_output("arst_level_before", level, 32'd5);
    check_output("arst_msg_count_before", msg_count, 32'd1);
    check_output("arst_overflow_before", overflow, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("arst_out_valid", bus.out_valid, 32'd0);
    check_output("arst_level", level, 32'd0);
    check_output("arst_msg_count", msg_count, 32'd0);
    check_output("arst_overflow", overflow, 32'd0);
    check_output("arst_bad_char", bad_char, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(8'h43); expect_beat(1'b0, 8'h43);
    check_output("arst_new_data", bus.out_data, 32'h43);
    check_output("arst_new_level", level, 32'd1);
    drain("arst");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
